// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Parametrised multi-port register file with two prioritised
//                write ports, optional write-to-read bypass, optional hardwired
//                zero entry and a post-reset clear sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREAD*ADDR_W-1:0]   ra,
    output logic [NREAD*DATA_W-1:0]   rdata,
    input  logic                      we0,
    input  logic [ADDR_W-1:0]         wa0,
    input  logic [DATA_W-1:0]         wd0,
    input  logic                      we1,
    input  logic [ADDR_W-1:0]         wa1,
    input  logic [DATA_W-1:0]         wd1,
    output logic                      ready
);

    localparam int              C_DEPTH    = 2**ADDR_W;
    localparam logic [0:0]      C_ST_CLEAR = 1'b0;
    localparam logic [0:0]      C_ST_RUN   = 1'b1;
    localparam logic [ADDR_W:0] C_CNT_LAST = (ADDR_W+1)'(C_DEPTH-1);
    localparam logic [ADDR_W:0] C_CNT_ONE  = (ADDR_W+1)'(1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W:0]   cnt_q,   cnt_d;
    logic [DATA_W-1:0] mem_q [C_DEPTH];
    logic [DATA_W-1:0] mem_d [C_DEPTH];

    logic w_run;
    logic w_wr0;
    logic w_wr1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (rst) begin
            state_d = C_ST_CLEAR;
            cnt_d   = '0;
        end else if (state_q == C_ST_CLEAR) begin
            cnt_d = cnt_q + C_CNT_ONE;
            if (cnt_q == C_CNT_LAST) begin
                state_d = C_ST_RUN;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic: a reset in flight hides the array immediately
    // ------------------------------------------------------------------
    always_comb begin
        w_run = (state_q == C_ST_RUN) && !rst;
        ready = w_run;
    end

    // Writes to a hardwired-zero entry are discarded before reaching storage
    always_comb begin
        w_wr0 = we0 && !((ZERO_REG != 0) && (wa0 == '0));
        w_wr1 = we1 && !((ZERO_REG != 0) && (wa1 == '0));
    end

    // ------------------------------------------------------------------
    // Storage update; port 1 is applied last so it wins a collision
    // ------------------------------------------------------------------
    always_comb begin
        mem_d = mem_q;
        if (!rst) begin
            if (state_q == C_ST_CLEAR) begin
                mem_d[cnt_q[ADDR_W-1:0]] = '0;
            end else begin
                if (w_wr0) begin
                    mem_d[wa0] = wd0;
                end
                if (w_wr1) begin
                    mem_d[wa1] = wd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // ------------------------------------------------------------------
    // Asynchronous read ports
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NREAD; gi++) begin : g_read
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;

        assign w_ra = ra[gi*ADDR_W +: ADDR_W];

        always_comb begin
            w_rd = mem_q[w_ra];
            if (!w_run) begin
                w_rd = '0;
            end else if ((ZERO_REG != 0) && (w_ra == '0)) begin
                w_rd = '0;
            end else if ((BYPASS != 0) && we1 && (wa1 == w_ra)) begin
                w_rd = wd1;
            end else if ((BYPASS != 0) && we0 && (wa0 == w_ra)) begin
                w_rd = wd0;
            end
        end

        assign rdata[gi*DATA_W +: DATA_W] = w_rd;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Directed self-checking bench for regfile_mp (default, no-zero
//                and narrow 4-read/no-bypass configurations).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default configuration
    logic [9:0]  a_ra = '0;
    logic [63:0] a_rdata;
    logic        a_we0 = 1'b0, a_we1 = 1'b0, a_ready;
    logic [4:0]  a_wa0 = '0, a_wa1 = '0;
    logic [31:0] a_wd0 = '0, a_wd1 = '0;

    // ZERO_REG = 0
    logic [9:0]  b_ra = '0;
    logic [63:0] b_rdata;
    logic        b_we0 = 1'b0, b_we1 = 1'b0, b_ready;
    logic [4:0]  b_wa0 = '0, b_wa1 = '0;
    logic [31:0] b_wd0 = '0, b_wd1 = '0;

    // DATA_W=16, ADDR_W=3, NREAD=4, BYPASS=0
    logic [11:0] c_ra = '0;
    logic [63:0] c_rdata;
    logic        c_we0 = 1'b0, c_we1 = 1'b0, c_ready;
    logic [2:0]  c_wa0 = '0, c_wa1 = '0;
    logic [15:0] c_wd0 = '0, c_wd1 = '0;

    regfile_mp u_dut_a (
        .clk(clk), .rst(rst), .ra(a_ra), .rdata(a_rdata),
        .we0(a_we0), .wa0(a_wa0), .wd0(a_wd0),
        .we1(a_we1), .wa1(a_wa1), .wd1(a_wd1), .ready(a_ready)
    );

    regfile_mp #(.ZERO_REG(0)) u_dut_b (
        .clk(clk), .rst(rst), .ra(b_ra), .rdata(b_rdata),
        .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0),
        .we1(b_we1), .wa1(b_wa1), .wd1(b_wd1), .ready(b_ready)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .NREAD(4), .BYPASS(0)) u_dut_c (
        .clk(clk), .rst(rst), .ra(c_ra), .rdata(c_rdata),
        .we0(c_we0), .wa0(c_wa0), .wd0(c_wd0),
        .we1(c_we1), .wa1(c_wa1), .wd1(c_wd1), .ready(c_ready)
    );

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs[14];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_c_ra(input logic [2:0] r0, input logic [2:0] r1,
                            input logic [2:0] r2, input logic [2:0] r3);
        c_ra = {r3, r2, r1, r0};
    endtask

    task automatic chk_c(input string name, input logic [15:0] e0, input logic [15:0] e1,
                         input logic [15:0] e2, input logic [15:0] e3);
        chk({name, "_l0"}, {48'd0, c_rdata[15:0]},  {48'd0, e0});
        chk({name, "_l1"}, {48'd0, c_rdata[31:16]}, {48'd0, e1});
        chk({name, "_l2"}, {48'd0, c_rdata[47:32]}, {48'd0, e2});
        chk({name, "_l3"}, {48'd0, c_rdata[63:48]}, {48'd0, e3});
    endtask

    // Cycles with ready low on DUT A, bounded so a stuck sequencer still ends
    task automatic count_a_clear(output int n);
        n = 0;
        while (!a_ready && n < 100) begin
            n++;
            step();
        end
    endtask

    initial begin
        int na, nc;

        //            we0   wa0    wd0            we1   wa1    wd1            ra0    ra1    exp0           exp1
        vecs[0]  = '{1'b1, 5'd3,  32'h12345678, 1'b0, 5'd0,  32'h0,        5'd3,  5'd4,  32'h12345678, 32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd3,  32'h0,        32'h12345678};
        vecs[2]  = '{1'b1, 5'd7,  32'hAAAA0000, 1'b1, 5'd7,  32'h5555FFFF, 5'd7,  5'd3,  32'h5555FFFF, 32'h12345678};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h5555FFFF, 32'h5555FFFF};
        vecs[4]  = '{1'b1, 5'd8,  32'h11111111, 1'b1, 5'd9,  32'h22222222, 5'd9,  5'd8,  32'h22222222, 32'h11111111};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd8,  5'd9,  32'h11111111, 32'h22222222};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd9,  32'h0,        32'h22222222};
        vecs[7]  = '{1'b1, 5'd0,  32'h12121212, 1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd31, 32'h0,        32'h0};
        vecs[9]  = '{1'b1, 5'd31, 32'h0BADF00D, 1'b1, 5'd3,  32'hCCCCCCCC, 5'd3,  5'd31, 32'hCCCCCCCC, 32'h0BADF00D};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd31, 5'd3,  32'h0BADF00D, 32'hCCCCCCCC};
        vecs[11] = '{1'b1, 5'd3,  32'h00000001, 1'b0, 5'd0,  32'h0,        5'd8,  5'd3,  32'h11111111, 32'h00000001};
        vecs[12] = '{1'b1, 5'd3,  32'h00000002, 1'b1, 5'd4,  32'h00000044, 5'd3,  5'd4,  32'h00000002, 32'h00000044};
        vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd3,  5'd4,  32'h00000002, 32'h00000044};

        // Reset state
        step();
        step();
        chk("rst_ready_a", {63'd0, a_ready}, 64'd0);
        chk("rst_rdata_a", a_rdata, 64'd0);
        chk("rst_ready_c", {63'd0, c_ready}, 64'd0);
        chk("rst_rdata_c", c_rdata, 64'd0);

        // Initial clear: DEPTH cycles of ready low
        rst = 1'b0;
        #1;
        na = 0;
        nc = 0;
        for (int k = 0; k < 100; k++) begin
            if (a_ready && c_ready) break;
            if (!a_ready) na++;
            if (!c_ready) nc++;
            step();
        end
        chk("clear_len_a", 64'(na), 64'd32);
        chk("clear_len_c", 64'(nc), 64'd8);

        // Preload then clear by reset pulse
        a_we0 = 1'b1; a_wa0 = 5'd5; a_wd0 = 32'hDEADBEEF;
        step();
        a_we0 = 1'b0;
        a_ra  = {5'd0, 5'd5};
        #1;
        chk("preload_rd5", {32'd0, a_rdata[31:0]}, 64'hDEADBEEF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("pulse_ready", {63'd0, a_ready}, 64'd0);
        chk("pulse_rdata", a_rdata, 64'd0);
        count_a_clear(na);
        chk("pulse_clear_len", 64'(na), 64'd32);
        #1;
        chk("after_clear_rd5", {32'd0, a_rdata[31:0]}, 64'd0);

        // Table-driven RUN traffic on DUT A, one cycle per row
        foreach (vecs[i]) begin
            a_we0 = vecs[i].we0; a_wa0 = vecs[i].wa0; a_wd0 = vecs[i].wd0;
            a_we1 = vecs[i].we1; a_wa1 = vecs[i].wa1; a_wd1 = vecs[i].wd1;
            a_ra  = {vecs[i].ra1, vecs[i].ra0};
            #1;
            chk($sformatf("vec%0d_lane0", i), {32'd0, a_rdata[31:0]},  {32'd0, vecs[i].exp0});
            chk($sformatf("vec%0d_lane1", i), {32'd0, a_rdata[63:32]}, {32'd0, vecs[i].exp1});
            step();
        end
        a_we0 = 1'b0; a_we1 = 1'b0;

        // Entry 0 as an ordinary register
        b_we1 = 1'b1; b_wa1 = 5'd0; b_wd1 = 32'hFFFFFFFF; b_ra = {5'd1, 5'd0};
        #1;
        chk("nozero_bypass", {32'd0, b_rdata[31:0]}, 64'hFFFFFFFF);
        step();
        b_we1 = 1'b0;
        #1;
        chk("nozero_stored", {32'd0, b_rdata[31:0]}, 64'hFFFFFFFF);
        chk("nozero_other",  {32'd0, b_rdata[63:32]}, 64'd0);

        // Reset mid-clear with writes presented throughout the clear
        rst = 1'b1;
        step();
        rst = 1'b0;
        a_we0 = 1'b1; a_wa0 = 5'd31; a_wd0 = 32'h00000001;
        a_we1 = 1'b1; a_wa1 = 5'd2;  a_wd1 = 32'h0000CAFE;
        a_ra  = {5'd2, 5'd8};
        step(); step(); step();
        chk("clear_hides_rd8", a_rdata, 64'd0);
        chk("clear_ready_low", {63'd0, a_ready}, 64'd0);
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        count_a_clear(na);
        a_we0 = 1'b0; a_we1 = 1'b0;
        chk("restart_clear_len", 64'(na), 64'd32);
        a_ra = {5'd2, 5'd31};
        #1;
        chk("clear_ignores_we0", {32'd0, a_rdata[31:0]},  64'd0);
        chk("clear_ignores_we1", {32'd0, a_rdata[63:32]}, 64'd0);
        a_ra = {5'd9, 5'd8};
        #1;
        chk("clear_wiped_8_9", a_rdata, 64'd0);

        // Narrow configuration: fill entries 1..7, try entry 0
        c_we0 = 1'b1; c_wa0 = 3'd1; c_wd0 = 16'h1111; c_we1 = 1'b1; c_wa1 = 3'd2; c_wd1 = 16'h2222;
        step();
        c_wa0 = 3'd3; c_wd0 = 16'h3333; c_wa1 = 3'd4; c_wd1 = 16'h4444;
        step();
        c_wa0 = 3'd5; c_wd0 = 16'h5555; c_wa1 = 3'd6; c_wd1 = 16'h6666;
        step();
        c_wa0 = 3'd7; c_wd0 = 16'h7777; c_wa1 = 3'd0; c_wd1 = 16'hFFFF;
        step();
        c_we0 = 1'b0; c_we1 = 1'b0;
        set_c_ra(3'd1, 3'd3, 3'd5, 3'd7);
        #1;
        chk_c("c_odd", 16'h1111, 16'h3333, 16'h5555, 16'h7777);
        set_c_ra(3'd2, 3'd4, 3'd6, 3'd0);
        #1;
        chk_c("c_even", 16'h2222, 16'h4444, 16'h6666, 16'h0000);
        set_c_ra(3'd7, 3'd0, 3'd2, 3'd5);
        #1;
        chk_c("c_mixed", 16'h7777, 16'h0000, 16'h2222, 16'h5555);

        // No bypass: same-cycle reads return the old contents
        c_we0 = 1'b1; c_wa0 = 3'd3; c_wd0 = 16'hBEEF;
        c_we1 = 1'b1; c_wa1 = 3'd6; c_wd1 = 16'hABCD;
        set_c_ra(3'd3, 3'd6, 3'd3, 3'd1);
        #1;
        chk_c("c_nobypass", 16'h3333, 16'h6666, 16'h3333, 16'h1111);
        step();
        c_we0 = 1'b0; c_we1 = 1'b0;
        #1;
        chk_c("c_after_write", 16'hBEEF, 16'hABCD, 16'hBEEF, 16'h1111);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
